// File: rtl/mvu_thresholding.sv
`default_nettype none
// ============================================================================
// Module      : mvu_thresholding
// Description : Streaming multi-threshold activation stage. After reset, it
//               loads NF*NThresh threshold words over s1. It then maps each
//               lane of every accumulator beat on s0 to the number of
//               thresholds of its output channel that the lane reaches or
//               exceeds, and emits the counts on m0.
// Ports       : aclk, aresetn          - clock, async active-low reset
//               s0_axis_*              - accumulator stream in (PE*TDstI)
//               s1_axis_*              - threshold word stream in (PE*TDstI)
//               m0_axis_*              - activation stream out (PE*TOut)
//               thr_loaded             - high once every threshold is stored
// Revision    : 1.0 - initial release
// ============================================================================
module mvu_thresholding #(
  parameter int OFMCh  = 2,
  parameter int PE     = 2,
  parameter int TDstI  = 8,
  parameter int TOut   = 2,
  parameter int TH_SGN = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [PE*TDstI-1:0]   s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [PE*TDstI-1:0]   s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  output logic [PE*TOut-1:0]    m0_axis_tdata,
  output logic                  m0_axis_tvalid,
  input  logic                  m0_axis_tready,
  output logic                  thr_loaded
);

  localparam int NF       = OFMCh / PE;
  localparam int N_THRESH = (1 << TOut) - 1;
  localparam int FW       = (NF > 1) ? $clog2(NF) : 1;
  localparam int TW       = (N_THRESH > 1) ? $clog2(N_THRESH) : 1;

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]           state_q,    state_d;
  logic [FW-1:0]        ld_fold_q,  ld_fold_d;
  logic [TW-1:0]        ld_t_q,     ld_t_d;
  logic [FW-1:0]        fold_q,     fold_d;
  logic                 m_valid_q,  m_valid_d;
  logic [PE*TOut-1:0]   m_data_q,   m_data_d;

  // Threshold words indexed [fold][threshold index]; lane p in bits p*TDstI.
  logic [PE*TDstI-1:0]  thr_q [NF][N_THRESH];

  logic                 s0_ready;
  logic                 s1_ready;
  logic                 acc_s0;
  logic                 acc_s1;
  logic [PE*TOut-1:0]   lanes_res;

  // s1 ready is gated by reset directly so that no word can be taken while
  // aresetn is low, even before the state register settles.
  assign s1_ready       = aresetn && (state_q == S_LOAD);
  assign s0_ready       = (state_q == S_RUN) && (!m_valid_q || m0_axis_tready);
  assign acc_s0         = s0_axis_tvalid && s0_ready;
  assign acc_s1         = s1_axis_tvalid && s1_ready;

  assign s0_axis_tready = s0_ready;
  assign s1_axis_tready = s1_ready;
  assign m0_axis_tdata  = m_data_q;
  assign m0_axis_tvalid = m_valid_q;
  assign thr_loaded     = (state_q == S_RUN);

  // --------------------------------------------------------------------------
  // Per-lane compare: a chain of adders counts the thresholds reached.
  // --------------------------------------------------------------------------
  genvar p, t;
  generate
    for (p = 0; p < PE; p++) begin : g_lane
      logic [N_THRESH-1:0] ge;
      logic [TOut-1:0]     cnt [N_THRESH+1];
      logic [TDstI-1:0]    acc;

      assign acc    = s0_axis_tdata[p*TDstI +: TDstI];
      assign cnt[0] = '0;

      for (t = 0; t < N_THRESH; t++) begin : g_thr
        logic [TDstI-1:0] th;
        assign th = thr_q[fold_q][t][p*TDstI +: TDstI];

        if (TH_SGN != 0) begin : g_sgn
          assign ge[t] = ($signed(acc) >= $signed(th));
        end else begin : g_uns
          assign ge[t] = (acc >= th);
        end

        assign cnt[t+1] = cnt[t] + TOut'(ge[t]);
      end

      assign lanes_res[p*TOut +: TOut] = cnt[N_THRESH];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ld_fold_d = ld_fold_q;
    ld_t_d    = ld_t_q;
    fold_d    = fold_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;

    // Load order is fold-major, threshold-index-minor; both counters return
    // to zero as the last word moves the block to RUN.
    if (acc_s1) begin
      if (ld_t_q == TW'(N_THRESH - 1)) begin
        ld_t_d = '0;
        if (ld_fold_q == FW'(NF - 1)) begin
          ld_fold_d = '0;
          state_d   = S_RUN;
        end else begin
          ld_fold_d = ld_fold_q + 1'b1;
        end
      end else begin
        ld_t_d = ld_t_q + 1'b1;
      end
    end

    // One-deep output register: a new beat may replace one that is draining
    // in the same cycle, which sustains one beat per cycle.
    if (acc_s0) begin
      m_valid_d = 1'b1;
      m_data_d  = lanes_res;
      fold_d    = (fold_q == FW'(NF - 1)) ? '0 : fold_q + 1'b1;
    end else if (m0_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Control and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_LOAD;
      ld_fold_q <= '0;
      ld_t_q    <= '0;
      fold_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      ld_fold_q <= ld_fold_d;
      ld_t_q    <= ld_t_d;
      fold_q    <= fold_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  // Threshold storage carries no reset: it is only read once every entry has
  // been rewritten by a complete load.
  always_ff @(posedge aclk) begin
    if (acc_s1) begin
      thr_q[ld_fold_q][ld_t_q] <= s1_axis_tdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mvu_thresholding.sv
`default_nettype none
// ============================================================================
// Module      : tb_mvu_thresholding
// Description : Testbench for mvu_thresholding. It uses three instances:
//               0 = default configuration with signed compare,
//               1 = OFMCh=4 (two channel folds), signed,
//               2 = unsigned compare.
//               Expected values come from a threshold table and a counting
//               model that works directly on integers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mvu_thresholding;

  logic              clk = 1'b0;
  logic              aresetn;
  logic [15:0]       s0_data;
  logic [15:0]       s1_data;
  logic [2:0]        s0_v;
  logic [2:0]        s1_v;
  logic [2:0]        rdy;
  logic [2:0][3:0]   m_data;
  logic [2:0]        m_valid;
  logic [2:0]        s0_rdy;
  logic [2:0]        s1_rdy;
  logic [2:0]        loaded;

  int checks   = 0;
  int failures = 0;
  int fold [3];
  int nf   [3] = '{1, 2, 1};
  bit sgn  [3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0] thr_tb [3][2][3][2];   // [dut][fold][threshold][lane]

  always #5 clk = ~clk;

  mvu_thresholding #(.OFMCh(2), .PE(2), .TDstI(8), .TOut(2), .TH_SGN(1)) u_a (
    .aclk(clk), .aresetn(aresetn),
    .s0_axis_tdata(s0_data), .s0_axis_tvalid(s0_v[0]), .s0_axis_tready(s0_rdy[0]),
    .s1_axis_tdata(s1_data), .s1_axis_tvalid(s1_v[0]), .s1_axis_tready(s1_rdy[0]),
    .m0_axis_tdata(m_data[0]), .m0_axis_tvalid(m_valid[0]), .m0_axis_tready(rdy[0]),
    .thr_loaded(loaded[0]));

  mvu_thresholding #(.OFMCh(4), .PE(2), .TDstI(8), .TOut(2), .TH_SGN(1)) u_b (
    .aclk(clk), .aresetn(aresetn),
    .s0_axis_tdata(s0_data), .s0_axis_tvalid(s0_v[1]), .s0_axis_tready(s0_rdy[1]),
    .s1_axis_tdata(s1_data), .s1_axis_tvalid(s1_v[1]), .s1_axis_tready(s1_rdy[1]),
    .m0_axis_tdata(m_data[1]), .m0_axis_tvalid(m_valid[1]), .m0_axis_tready(rdy[1]),
    .thr_loaded(loaded[1]));

  mvu_thresholding #(.OFMCh(2), .PE(2), .TDstI(8), .TOut(2), .TH_SGN(0)) u_c (
    .aclk(clk), .aresetn(aresetn),
    .s0_axis_tdata(s0_data), .s0_axis_tvalid(s0_v[2]), .s0_axis_tready(s0_rdy[2]),
    .s1_axis_tdata(s1_data), .s1_axis_tvalid(s1_v[2]), .s1_axis_tready(s1_rdy[2]),
    .m0_axis_tdata(m_data[2]), .m0_axis_tvalid(m_valid[2]), .m0_axis_tready(rdy[2]),
    .thr_loaded(loaded[2]));

  // Reference: each lane counts the thresholds it reaches (equality counts).
  function automatic logic [3:0] model(int d, int f, logic [15:0] acc);
    logic [3:0] r;
    logic [7:0] a;
    logic [7:0] th;
    int         c;
    r = '0;
    for (int p = 0; p < 2; p++) begin
      a = acc[p*8 +: 8];
      c = 0;
      for (int t = 0; t < 3; t++) begin
        th = thr_tb[d][f][t][p];
        if (sgn[d] ? ($signed(a) >= $signed(th)) : (a >= th)) c++;
      end
      r[p*2 +: 2] = c[1:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s0_v = '0; s1_v = '0; rdy = 3'b111; s0_data = '0; s1_data = '0;
    repeat (2) tick();
    for (int d = 0; d < 3; d++) begin
      checks++; if (m_valid[d] !== 1'b0) begin failures++; $display("FAIL reset_tvalid dut=%0d got=%b exp=0", d, m_valid[d]); end
      checks++; if (m_data[d] !== 4'h0) begin failures++; $display("FAIL reset_tdata dut=%0d got=%h exp=0", d, m_data[d]); end
      checks++; if (loaded[d] !== 1'b0) begin failures++; $display("FAIL reset_loaded dut=%0d got=%b exp=0", d, loaded[d]); end
      checks++; if (s0_rdy[d] !== 1'b0) begin failures++; $display("FAIL reset_s0_ready dut=%0d got=%b exp=0", d, s0_rdy[d]); end
      checks++; if (s1_rdy[d] !== 1'b0) begin failures++; $display("FAIL reset_s1_ready dut=%0d got=%b exp=0", d, s1_rdy[d]); end
    end
    aresetn = 1'b1;
    #1;
    checks++; if (s1_rdy !== 3'b111) begin failures++; $display("FAIL reset_release_s1_ready got=%b exp=111", s1_rdy); end
    for (int d = 0; d < 3; d++) fold[d] = 0;
  endtask

  // Loads all threshold words of one instance from the table, checking the
  // stray-input behaviour on both sides and the timing of thr_loaded.
  task automatic test_load(int d);
    int  words;
    int  n;
    bit  ok;
    words = nf[d] * 3;
    s0_data = 16'($urandom);
    s0_v[d] = 1'b1;
    #1;
    checks++; if (s0_rdy[d] !== 1'b0) begin failures++; $display("FAIL stray_s0_in_load dut=%0d got=%b exp=0", d, s0_rdy[d]); end
    tick();
    s0_v[d] = 1'b0;
    n = 0;
    for (int f = 0; f < nf[d]; f++) begin
      for (int t = 0; t < 3; t++) begin
        s1_data = {thr_tb[d][f][t][1], thr_tb[d][f][t][0]};
        s1_v[d] = 1'b1;
        #1;
        ok = 1'b0;
        for (int w = 0; w < 10 && !ok; w++) begin
          ok = s1_rdy[d];
          if (n == words - 1) begin
            checks++; if (loaded[d] !== 1'b0) begin failures++; $display("FAIL loaded_early dut=%0d got=%b exp=0", d, loaded[d]); end
          end
          tick();
        end
        if (!ok) begin
          failures++; $display("FAIL load_timeout dut=%0d word=%0d got=no_ready exp=ready", d, n);
        end
        n++;
      end
    end
    s1_v[d] = 1'b0;
    #1;
    checks++; if (loaded[d] !== 1'b1) begin failures++; $display("FAIL loaded_after_last dut=%0d got=%b exp=1", d, loaded[d]); end
    checks++; if (s1_rdy[d] !== 1'b0) begin failures++; $display("FAIL s1_ready_in_run dut=%0d got=%b exp=0", d, s1_rdy[d]); end
    s1_data = 16'($urandom);
    s1_v[d] = 1'b1;
    #1;
    checks++; if (s1_rdy[d] !== 1'b0) begin failures++; $display("FAIL stray_s1_in_run dut=%0d got=%b exp=0", d, s1_rdy[d]); end
    tick();
    s1_v[d] = 1'b0;
    fold[d] = 0;
  endtask

  task automatic test_basic();
    logic [3:0] exp;
    exp = model(0, fold[0], 16'h2805);
    s0_data = 16'h2805;
    s0_v[0] = 1'b1;
    #1;
    checks++; if (s0_rdy[0] !== 1'b1) begin failures++; $display("FAIL basic_s0_ready got=%b exp=1", s0_rdy[0]); end
    tick();
    s0_v[0] = 1'b0;
    fold[0] = (fold[0] + 1) % nf[0];
    checks++; if (m_valid[0] !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", m_valid[0]); end
    checks++; if (m_data[0] !== 4'b1110) begin failures++; $display("FAIL basic_data got=%b exp=1110", m_data[0]); end
    checks++; if (m_data[0] !== exp) begin failures++; $display("FAIL basic_model got=%b exp=%b", m_data[0], exp); end
    tick();
    checks++; if (m_valid[0] !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", m_valid[0]); end
  endtask

  // Single beats on one instance: fixed boundary values first, then random.
  task automatic test_beats(int d, string name, logic [15:0] fixed[$], int n_rand);
    logic [15:0] v [$];
    logic [3:0]  exp;
    v = fixed;
    for (int i = 0; i < n_rand; i++) v.push_back(16'($urandom));
    foreach (v[i]) begin
      exp = model(d, fold[d], v[i]);
      s0_data = v[i];
      s0_v[d] = 1'b1;
      #1;
      tick();
      s0_v[d] = 1'b0;
      fold[d] = (fold[d] + 1) % nf[d];
      checks++;
      if (m_valid[d] !== 1'b1 || m_data[d] !== exp) begin
        failures++;
        $display("FAIL %s beat=%0d in=%h got=%b/%b exp=1/%b", name, i, v[i], m_valid[d], m_data[d], exp);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] beats [8];
    logic [3:0]  exp0;
    logic [3:0]  exp;
    rdy[0] = 1'b0;
    s0_data = 16'($urandom);
    exp0 = model(0, fold[0], s0_data);
    s0_v[0] = 1'b1;
    #1;
    tick();
    fold[0] = (fold[0] + 1) % nf[0];
    for (int i = 0; i < 8; i++) beats[i] = 16'($urandom);
    s0_data = beats[0];
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (s0_rdy[0] !== 1'b0 || m_valid[0] !== 1'b1 || m_data[0] !== exp0) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d got=rdy%b/v%b/%b exp=rdy0/v1/%b", c, s0_rdy[0], m_valid[0], m_data[0], exp0);
      end
      tick();
    end
    rdy[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s0_data = beats[i];
      exp = model(0, fold[0], beats[i]);
      #1;
      checks++; if (s0_rdy[0] !== 1'b1) begin failures++; $display("FAIL stream_ready beat=%0d got=%b exp=1", i, s0_rdy[0]); end
      tick();
      fold[0] = (fold[0] + 1) % nf[0];
      checks++;
      if (m_valid[0] !== 1'b1 || m_data[0] !== exp) begin
        failures++; $display("FAIL stream_data beat=%0d got=%b/%b exp=1/%b", i, m_valid[0], m_data[0], exp);
      end
    end
    s0_v[0] = 1'b0;
    tick();
    checks++; if (m_valid[0] !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", m_valid[0]); end
  endtask

  // Two folds streamed back to back: identical inputs must alternate
  // between the fold-0 and fold-1 threshold sets.
  task automatic test_fold();
    logic [3:0] exp;
    logic [3:0] lit;
    logic [15:0] v;
    s0_v[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v = (i < 6) ? 16'h1E1E : 16'($urandom);
      s0_data = v;
      exp = model(1, fold[1], v);
      lit = (i % 2 == 0) ? 4'hF : 4'h0;
      #1;
      tick();
      fold[1] = (fold[1] + 1) % nf[1];
      checks++;
      if (m_valid[1] !== 1'b1 || m_data[1] !== exp) begin
        failures++; $display("FAIL fold_model beat=%0d got=%b/%b exp=1/%b", i, m_valid[1], m_data[1], exp);
      end
      if (i < 6) begin
        checks++; if (m_data[1] !== lit) begin failures++; $display("FAIL fold_alternate beat=%0d got=%b exp=%b", i, m_data[1], lit); end
      end
    end
    s0_v[1] = 1'b0;
    tick();
    checks++; if (m_valid[1] !== 1'b0) begin failures++; $display("FAIL fold_drain got=%b exp=0", m_valid[1]); end
  endtask

  task automatic test_unsigned();
    logic [15:0] fixed [$];
    fixed = '{16'hC8C8, 16'h8080, 16'h6464, 16'h63C7};
    test_beats(2, "unsigned", fixed, 6);
    checks++; if (model(2, 0, 16'hC8C8) !== 4'hF || model(2, 0, 16'h8080) !== 4'b0101)
      begin failures++; $display("FAIL unsigned_table got=%b,%b exp=1111,0101", model(2, 0, 16'hC8C8), model(2, 0, 16'h8080)); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] fixed [$];
    rdy[0] = 1'b0;
    s0_data = 16'h2805;
    s0_v[0] = 1'b1;
    #1;
    tick();
    s0_v[0] = 1'b0;
    #1;
    checks++; if (m_valid[0] !== 1'b1) begin failures++; $display("FAIL midreset_pre_valid got=%b exp=1", m_valid[0]); end
    aresetn = 1'b0;
    #1;
    checks++; if (m_valid[0] !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", m_valid[0]); end
    checks++; if (loaded !== 3'b000) begin failures++; $display("FAIL midreset_loaded got=%b exp=000", loaded); end
    checks++; if (s1_rdy !== 3'b000) begin failures++; $display("FAIL midreset_s1_gated got=%b exp=000", s1_rdy); end
    tick();
    aresetn = 1'b1;
    rdy[0] = 1'b1;
    #1;
    checks++; if (s1_rdy[0] !== 1'b1 || loaded[0] !== 1'b0) begin failures++; $display("FAIL midreset_release got=s1rdy%b/ld%b exp=1/0", s1_rdy[0], loaded[0]); end
    for (int d = 0; d < 3; d++) fold[d] = 0;
    test_load(0);
    test_basic();
    test_load(1);
    fixed = '{16'h1E1E, 16'h1E1E};
    test_beats(1, "midreset_fold", fixed, 2);
  endtask

  initial begin
    // dut0: lane0 {-10,0,10}, lane1 {0,20,40}
    thr_tb[0][0][0] = '{8'hF6, 8'd0};
    thr_tb[0][0][1] = '{8'd0,  8'd20};
    thr_tb[0][0][2] = '{8'd10, 8'd40};
    thr_tb[0][1][0] = '{8'd0, 8'd0};
    thr_tb[0][1][1] = '{8'd0, 8'd0};
    thr_tb[0][1][2] = '{8'd0, 8'd0};
    // dut1: fold0 {0,10,20}, fold1 = fold0 + 50, both lanes
    for (int t = 0; t < 3; t++) begin
      thr_tb[1][0][t] = '{8'(t * 10), 8'(t * 10)};
      thr_tb[1][1][t] = '{8'(t * 10 + 50), 8'(t * 10 + 50)};
    end
    // dut2: {100,150,200}, both lanes, unsigned
    for (int t = 0; t < 3; t++) begin
      thr_tb[2][0][t] = '{8'(100 + t * 50), 8'(100 + t * 50)};
      thr_tb[2][1][t] = '{8'd0, 8'd0};
    end

    test_reset();
    test_load(0);
    test_load(1);
    test_load(2);
    test_basic();
    test_beats(0, "boundary", '{16'hFF80, 16'h00F6, 16'h277F, 16'h1400, 16'h13FF}, 8);
    test_backpressure();
    test_fold();
    test_unsigned();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
